// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port SRAM between fetch and data ports with wait states and starvation guard
module mem_port_arbiter #(
  parameter int WAIT_STATES  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ready,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_oe,
  input  logic [15:0] mem_rdata,
  output logic        stall,
  output logic [1:0]  grant
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [2:0] SL = 3'(STARVE_LIMIT);
  localparam logic [1:0] OP_FETCH = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b11;
  state_t      state, state_nx;
  logic [1:0]  op, op_nx;
  logic [3:0]  cnt;
  logic [2:0]  starve;
  logic        acc, resp, take;
  always_comb begin
    op_nx    = (if_req && starve == SL) ? OP_FETCH :
               d_write ? OP_WRITE : d_read ? OP_READ : if_req ? OP_FETCH : 2'b00;
    take     = state == IDLE && op_nx != 2'b00;
    state_nx = state == IDLE   ? (take ? ACCESS : IDLE) :
               state == ACCESS ? (cnt == 4'd0 ? RESP : ACCESS) : IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      op        <= 2'b00;
      cnt       <= 4'd0;
      starve    <= 3'd0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      if_rdata  <= 16'h0000;
      d_rdata   <= 16'h0000;
    end else begin
      state <= state_nx;
      if (take) begin
        op        <= op_nx;
        cnt       <= WS;
        mem_addr  <= op_nx == OP_FETCH ? if_addr : d_addr;
        mem_wdata <= d_wdata;
        // data wins only count against fetch when fetch is actually waiting
        starve    <= op_nx == OP_FETCH ? 3'd0 :
                     (if_req && starve != SL) ? starve + 3'd1 : starve;
      end
      if (acc) begin
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
        if (cnt == 4'd0 && op == OP_FETCH) if_rdata <= mem_rdata;
        if (cnt == 4'd0 && op == OP_READ) d_rdata <= mem_rdata;
      end
    end
  end
  assign acc      = state == ACCESS;
  assign resp     = state == RESP;
  assign mem_oe   = acc && op != OP_WRITE;
  assign mem_we   = acc && op == OP_WRITE && cnt != 4'd0;
  assign if_ready = resp && op == OP_FETCH;
  assign d_ready  = resp && op[1];
  assign grant    = state == IDLE ? 2'b00 : op;
  assign stall    = (if_req & ~if_ready) | ((d_read | d_write) & ~d_ready);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of the SRAM port arbiter against a transaction-timeline model
module tb_mem_port_arbiter;
  localparam int W = 2;
  localparam int L = 3;
  logic        clock, reset;
  logic        if_req, d_read, d_write;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, d_ready, mem_we, mem_oe, stall;
  logic [1:0]  grant;
  logic        if_req1, d_write1;
  logic [15:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
  logic        if_ready1, d_ready1, mem_we1, mem_oe1, stall1;
  logic [1:0]  grant1;
  logic [15:0] env_mem   [0:65535];
  logic [15:0] model_mem [0:65535];
  int n_cmp = 0;
  int n_bad = 0;
  mem_port_arbiter #(.WAIT_STATES(W), .STARVE_LIMIT(L)) dut (
    .clock(clock), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_oe(mem_oe), .mem_rdata(mem_rdata), .stall(stall), .grant(grant));
  mem_port_arbiter #(.WAIT_STATES(1), .STARVE_LIMIT(L)) dut1 (
    .clock(clock), .reset(reset), .if_req(if_req1), .if_addr(16'h0040), .if_rdata(if_rdata1),
    .if_ready(if_ready1), .d_read(1'b0), .d_write(d_write1), .d_addr(16'h0080), .d_wdata(16'h7777),
    .d_rdata(d_rdata1), .d_ready(d_ready1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_we(mem_we1), .mem_oe(mem_oe1), .mem_rdata(16'h5A5A), .stall(stall1), .grant(grant1));
  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  // SRAM environment: written mid-cycle while the write strobe is high
  assign mem_rdata = mem_oe ? env_mem[mem_addr] : 16'hDEAD;
  always @(negedge clock) if (mem_we) env_mem[mem_addr] = mem_wdata;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference: each accepted transaction occupies W+1 access cycles then one response cycle
  bit          valid = 0;
  bit          busy = 0;
  int          age = 0;
  int          kind = 0;
  int          starve = 0;
  logic [15:0] m_addr, m_wdata;
  logic [15:0] exp_if = 0, exp_d = 0;
  always @(posedge clock) begin
    if (reset) begin
      busy = 0; starve = 0; exp_if = 0; exp_d = 0; valid = 1;
    end else if (valid) begin
      if (busy) begin
        if (age == W + 1 && kind == 1) exp_if = model_mem[m_addr];
        if (age == W + 1 && kind == 2) exp_d = model_mem[m_addr];
        if (age == W + 2) busy = 0; else age++;
      end else begin
        kind = (if_req && starve == L) ? 1 : d_write ? 3 : d_read ? 2 : if_req ? 1 : 0;
        if (kind != 0) begin
          busy = 1; age = 1;
          m_addr = kind == 1 ? if_addr : d_addr;
          m_wdata = d_wdata;
          if (kind == 3) model_mem[d_addr] = d_wdata;
          starve = kind == 1 ? 0 : (if_req ? ((starve < L) ? starve + 1 : L) : starve);
        end
      end
    end
  end
  always @(negedge clock) begin
    bit in_acc, rsp, e_if, e_d;
    if (valid) begin
      in_acc = busy && age <= W + 1;
      rsp = busy && age == W + 2;
      e_if = rsp && kind == 1;
      e_d = rsp && kind != 1;
      chk("mem_oe", 16'(mem_oe), 16'(in_acc && kind != 3));
      chk("mem_we", 16'(mem_we), 16'(in_acc && kind == 3 && age <= W));
      if (in_acc) chk("mem_addr", mem_addr, m_addr);
      if (in_acc && kind == 3) chk("mem_wdata", mem_wdata, m_wdata);
      chk("if_ready", 16'(if_ready), 16'(e_if));
      chk("d_ready", 16'(d_ready), 16'(e_d));
      chk("grant", 16'(grant), busy ? 16'(kind) : 16'd0);
      chk("if_rdata", if_rdata, exp_if);
      chk("d_rdata", d_rdata, exp_d);
      chk("stall", 16'(stall), 16'((if_req && !e_if) || ((d_read || d_write) && !e_d)));
    end
  end
  logic if_rdy_s, d_rdy_s;
  always @(negedge clock) begin
    if_rdy_s = if_ready;
    d_rdy_s = d_ready;
  end
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic run_op(input int n, output int oe_n, output int we_n, output int rdy_n,
                        output int rdy_at, output int st_n, output logic [1:0] g);
    oe_n = 0; we_n = 0; rdy_n = 0; rdy_at = -1; st_n = 0; g = 2'b00;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      oe_n += int'(mem_oe);
      we_n += int'(mem_we);
      st_n += int'(stall);
      if (grant != 2'b00) g = grant;
      if (if_ready || d_ready) begin
        rdy_n++;
        if (rdy_at < 0) rdy_at = k;
        tick;
        if_req = 0; d_read = 0; d_write = 0;
      end
    end
  endtask
  function automatic logic [15:0] pick_addr();
    int r = $urandom_range(0, 4);
    return r == 0 ? 16'h0010 : r == 1 ? 16'h0200 : r == 2 ? 16'hFFFE : r == 3 ? 16'h0300
         : 16'($urandom) & 16'hFFFE;
  endfunction
  initial begin
    int oe_n, we_n, rdy_n, rdy_at, st_n, n, at;
    logic [1:0] g, pg;
    logic [1:0] seq [8];
    logic [1:0] exp_seq [8];
    exp_seq = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 65536; i++) begin env_mem[i] = 16'h0; model_mem[i] = 16'h0; end
    env_mem[16'h0010] = 16'h1234;
    model_mem[16'h0010] = 16'h1234;
    reset = 1; if_req = 0; d_read = 0; d_write = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    if_req1 = 0; d_write1 = 0;
    tick; tick;
    @(negedge clock);
    chk("reset mem_addr", mem_addr, 16'h0000);
    chk("reset mem_wdata", mem_wdata, 16'h0000);
    chk("reset grant", 16'(grant), 16'h0000);
    chk("reset if_rdata", if_rdata, 16'h0000);
    tick;
    reset = 0; if_req = 1; if_addr = 16'h0010;
    run_op(8, oe_n, we_n, rdy_n, rdy_at, st_n, g);
    chk("fetch latency", 16'(rdy_at), 16'd4);
    chk("fetch oe cycles", 16'(oe_n), 16'd3);
    chk("fetch stall cycles", 16'(st_n), 16'd4);
    chk("fetch ready pulses", 16'(rdy_n), 16'd1);
    chk("fetch data held", if_rdata, 16'h1234);
    tick;
    d_write = 1; d_addr = 16'h0200; d_wdata = 16'hBEEF;
    run_op(8, oe_n, we_n, rdy_n, rdy_at, st_n, g);
    chk("write we cycles", 16'(we_n), 16'd2);
    chk("write latency", 16'(rdy_at), 16'd4);
    chk("write grant", 16'(g), 16'h0003);
    tick;
    d_read = 1; d_addr = 16'h0200;
    run_op(8, oe_n, we_n, rdy_n, rdy_at, st_n, g);
    chk("readback data", d_rdata, 16'hBEEF);
    chk("read grant", 16'(g), 16'h0002);
    tick;
    d_read = 1; d_write = 1; d_addr = 16'h0300; d_wdata = 16'h5555;
    run_op(8, oe_n, we_n, rdy_n, rdy_at, st_n, g);
    chk("both oe cycles", 16'(oe_n), 16'd0);
    chk("both we cycles", 16'(we_n), 16'd2);
    chk("both ready pulses", 16'(rdy_n), 16'd1);
    chk("both grant", 16'(g), 16'h0003);
    tick;
    d_write = 1; d_addr = 16'h0400; d_wdata = 16'h1111;
    tick; tick;
    reset = 1; d_write = 0;
    tick;
    reset = 0;
    @(negedge clock);
    chk("abort mem_we", 16'(mem_we), 16'h0000);
    chk("abort grant", 16'(grant), 16'h0000);
    run_op(6, oe_n, we_n, rdy_n, rdy_at, st_n, g);
    chk("abort no ready", 16'(rdy_n), 16'd0);
    tick;
    if_req = 1; if_addr = 16'h0010;
    run_op(8, oe_n, we_n, rdy_n, rdy_at, st_n, g);
    chk("post-abort fetch latency", 16'(rdy_at), 16'd4);
    tick;
    if_req = 1; d_read = 1; if_addr = pick_addr(); d_addr = pick_addr();
    n = 0; pg = 2'b00;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (grant != 2'b00 && pg == 2'b00 && n < 8) begin seq[n] = grant; n++; end
      pg = grant;
      if (if_ready || d_ready) begin
        tick;
        if (if_rdy_s) if_addr = pick_addr();
        if (d_rdy_s) d_addr = pick_addr();
      end
    end
    chk("starve grant count", 16'(n), 16'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("starve order %0d", i), 16'(seq[i]), 16'(exp_seq[i]));
    tick;
    if_req = 0; d_read = 0;
    repeat (10) tick;
    for (int c = 0; c < 3000; c++) begin
      reset = $urandom_range(0, 249) == 0;
      if (!if_req || if_rdy_s) begin
        if_req = $urandom_range(0, 2) != 0;
        if_addr = pick_addr();
      end
      if (!(d_read || d_write) || d_rdy_s) begin
        int r = $urandom_range(0, 5);
        d_read = r == 2 || r == 3 || r == 5;
        d_write = r >= 4;
        d_addr = pick_addr();
        d_wdata = 16'($urandom);
      end
      tick;
    end
    reset = 0; if_req = 0; d_read = 0; d_write = 0;
    repeat (10) tick;
    if_req1 = 1; at = -1; oe_n = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      oe_n += int'(mem_oe1);
      if (if_ready1 && at < 0) begin at = k; tick; if_req1 = 0; end
    end
    chk("ws1 fetch latency", 16'(at), 16'd3);
    chk("ws1 oe cycles", 16'(oe_n), 16'd2);
    chk("ws1 fetch data", if_rdata1, 16'h5A5A);
    tick;
    d_write1 = 1; at = -1; we_n = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      we_n += int'(mem_we1);
      if (d_ready1 && at < 0) begin at = k; tick; d_write1 = 0; end
    end
    chk("ws1 write latency", 16'(at), 16'd3);
    chk("ws1 we cycles", 16'(we_n), 16'd1);
    repeat (3) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external single-port 16-bit SRAM on the Spartan-3E board between the pipeline's instruction-fetch port and its data (MEM-stage) port.
- Serialises requests, generates SRAM strobes with a programmable wait-state count, and returns data and ready pulses.
- Drives a combined stall that the pipeline uses to hold PC and freeze IF/ID.
- Data accesses have priority; a starvation limit guarantees forward progress for instruction fetch.

Parameters:
WAIT_STATES, 2, extra SRAM cycles per access; legal range 1..15; one access occupies WAIT_STATES+1 cycles.
STARVE_LIMIT, 3, maximum consecutive data grants while fetch is pending before fetch is forced; legal range 1..7.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
if_req  input  1  fetch request; held until if_ready
if_addr  input  16  fetch byte address
if_rdata  output  16  fetched instruction; valid with if_ready, held until the next fetch completes
if_ready  output  1  one-cycle fetch-complete pulse
d_read  input  1  data read request; held until d_ready
d_write  input  1  data write request; held until d_ready
d_addr  input  16  data byte address
d_wdata  input  16  store data
d_rdata  output  16  load data; valid with d_ready, held until the next data read completes
d_ready  output  1  one-cycle data-complete pulse
mem_addr  output  16  SRAM address
mem_wdata  output  16  SRAM write data
mem_we  output  1  SRAM write strobe, active-high
mem_oe  output  1  SRAM output enable, active-high
mem_rdata  input  16  SRAM read data
stall  output  1  pipeline hold
grant  output  2  debug: 00 none, 01 fetch, 10 data read, 11 data write

Behaviour:
- Reset values: state IDLE, mem_we=0, mem_oe=0, mem_addr=0, mem_wdata=0, if_ready=0, d_ready=0, if_rdata=0, d_rdata=0, grant=00, wait counter=0, starve counter=0.
- Reset asserted mid-access aborts the access at the next edge: strobes go low and no ready pulse is produced.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, arbitration in priority order:
  - if_req=1 and starve counter==STARVE_LIMIT: grant fetch.
  - else d_write=1: grant data write.
  - else d_read=1: grant data read.
  - else if_req=1: grant fetch.
  - else stay in IDLE.
- On a grant: at the same edge, register the address, write data and operation; load the wait counter with WAIT_STATES; go to ACCESS.
- d_read and d_write both high is treated as a write. Exactly one d_ready is produced, and no read occurs.
- ACCESS:
  - mem_addr = latched address for the whole state.
  - Reads: mem_oe=1 for all ACCESS cycles.
  - Writes: mem_wdata = latched data for all ACCESS cycles; mem_we=1 for every ACCESS cycle except the last, which is the address/data hold cycle.
  - The counter decrements each cycle. In the cycle where counter==0, reads capture mem_rdata into the port's rdata register, and the FSM goes to RESP.
- RESP:
  - The granted port's ready is 1 for exactly this cycle; strobes are 0.
  - The FSM returns to IDLE unconditionally. The requester must have dropped or replaced its request by then, so the same request is never re-granted.
- Latency (request seen in IDLE to ready): WAIT_STATES+2 cycles. With the default of 2 this is 4 cycles; the next grant can occur in the cycle after RESP.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, on each data grant made while if_req=1.
  - Clears on every fetch grant.
  - Unchanged on data grants made while if_req=0.
- grant reflects the latched operation during ACCESS and RESP; it is 00 in IDLE.
- stall (combinational) = (if_req & ~if_ready) | ((d_read|d_write) & ~d_ready).
- Addresses pass through unmodified; byte addressing is the pipeline's concern. There is no wrap logic: 0xFFFE is a legal address.
- Request inputs that change during ACCESS have no effect on the access in progress.

Test Plan:
- Reset, then if_req=1, if_addr=0x0010, SRAM word 0x1234: mem_oe high for 3 cycles with mem_addr=0x0010; if_ready pulses once 4 cycles after the request; if_rdata=0x1234 and held afterwards; stall high for 4 cycles.
- d_write=1, d_addr=0x0200, d_wdata=0xBEEF: mem_we high for exactly 2 cycles followed by 1 hold cycle; d_ready pulses; read-back via d_read returns 0xBEEF.
- if_req and d_read held continuously, each request re-issued after its ready: grant order data, data, data, fetch, data, ...; fetch never waits more than 3 data grants.
- d_read=1 and d_write=1 together at 0x0300: one write occurs (mem_oe never asserted); a single d_ready pulse; grant=11.
- Reset asserted in the 2nd ACCESS cycle of a write: next cycle mem_we=0, state IDLE, no d_ready; a subsequent fetch completes normally in 4 cycles.
- WAIT_STATES=1: fetch latency is 3 cycles; the mem_we pulse is 1 cycle on writes.
